// File: rtl/pipeline_stage_reg.sv
// Inter-stage pipeline register with valid/ready flow control, synchronous flush
// and an optional two-entry skid buffer that keeps in_ready a registered signal.
module pipeline_stage_reg #(
    parameter int unsigned      WIDTH        = 64,
    parameter bit               SKID         = 1'b1,
    parameter logic [WIDTH-1:0] BUBBLE_VAL   = '0,
    parameter bit               CLR_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] main_q;
    logic             accept;
    logic             emit;

    assign accept   = in_valid & in_ready;
    assign emit     = out_valid & out_ready;
    // Held data is masked while empty so downstream always sees a clean bubble.
    assign out_data = out_valid ? main_q : BUBBLE_VAL;

    if (SKID) begin : g_skid
        // The state encoding doubles as the occupancy count.
        typedef enum logic [1:0] {
            ST_EMPTY = 2'd0,
            ST_ONE   = 2'd1,
            ST_FULL  = 2'd2
        } state_e;

        state_e           state_q;
        logic             in_ready_q;
        logic [WIDTH-1:0] skid_q;

        assign in_ready  = in_ready_q;
        assign out_valid = (state_q != ST_EMPTY);
        assign occupancy = state_q;

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                state_q    <= ST_EMPTY;
                in_ready_q <= 1'b1;
                if (CLR_ON_FLUSH) begin
                    main_q <= BUBBLE_VAL;
                    skid_q <= BUBBLE_VAL;
                end
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (accept) begin
                            main_q  <= in_data;
                            state_q <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (accept && !emit) begin
                            skid_q     <= in_data;
                            state_q    <= ST_FULL;
                            in_ready_q <= 1'b0;
                        end else if (accept && emit) begin
                            main_q <= in_data;
                        end else if (emit) begin
                            state_q <= ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (emit) begin
                            main_q     <= skid_q;
                            state_q    <= ST_ONE;
                            in_ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q    <= ST_EMPTY;
                        in_ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end else begin : g_single
        logic             valid_q;
        logic             valid_d;
        logic [WIDTH-1:0] main_d;

        // Combinational ready: a full stage can take a new word only if the
        // current one leaves in the same cycle.
        assign in_ready  = !valid_q | out_ready;
        assign out_valid = valid_q;
        assign occupancy = {1'b0, valid_q};

        always_comb begin
            valid_d = valid_q;
            main_d  = main_q;
            if (rst || flush) begin
                valid_d = 1'b0;
                if (CLR_ON_FLUSH) begin
                    main_d = BUBBLE_VAL;
                end
            end else if (accept) begin
                valid_d = 1'b1;
                main_d  = in_data;
            end else if (emit) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            valid_q <= valid_d;
            main_q  <= main_d;
        end
    end

endmodule
